// File: rtl/aes_128_decrypt_iter.sv
// aes_128_decrypt_iter: iterative AES-128 decryptor, one inverse round per clock with an on-the-fly inverse key schedule
// Ports: clk, rst (sync, active-high); in_valid/in_ready/ciphertext/key accept one block;
//        out_valid/out_ready/plaintext return it. KEY_CACHE=1 keeps the last round-10 key so a repeated key skips expansion.
module aes_128_decrypt_iter #(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);
  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] n);
    return n == 4'd9 ? 8'h1b : n == 4'd10 ? 8'h36 : (n >= 4'd1 && n <= 4'd8) ? 8'(1 << (n - 4'd1)) : 8'h00;
  endfunction
  function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  // undo one forward step: the last three words first, then w0 from the recovered w3
  function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [31:0] inv_mix(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction
  // byte i sits at row i%4, column i/4; InvShiftRows pulls row r from column (c - r) mod 4
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t, m;
    for (int i = 0; i < 16; i++)
      t[127-8*i -: 8] = isbox(s[127-8*(4*(((i/4) - (i%4) + 4) % 4) + (i%4)) -: 8]);
    t = t ^ k;
    for (int c = 0; c < 4; c++)
      m[127-32*c -: 32] = inv_mix(t[127-32*c -: 32]);
    return last ? t : m;
  endfunction
  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [127:0] st_q, rk_q, key_c_q, k10_c_q;
  logic         cv_q, out_valid_q;
  logic [127:0] k_fwd, k_inv, rnd;
  logic         hit;
  assign k_fwd     = fwd_key(rk_q, rcon(cnt_q));
  assign k_inv     = inv_key(rk_q, rcon(cnt_q + 4'd1));
  assign rnd       = inv_round(st_q, k_inv, cnt_q == 4'd0);
  assign hit       = KEY_CACHE && cv_q && key == key_c_q;
  assign in_ready  = state_q == IDLE && !rst;
  assign out_valid = out_valid_q;
  assign plaintext = out_valid_q ? st_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      rk_q        <= '0;
      key_c_q     <= '0;
      k10_c_q     <= '0;
      cv_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          cnt_q   <= hit ? 4'd9 : 4'd1;
          rk_q    <= hit ? k10_c_q : key;
          st_q    <= hit ? ciphertext ^ k10_c_q : ciphertext;
          state_q <= hit ? DEC : KEXP;
          if (!hit) begin
            key_c_q <= key;
            cv_q    <= 1'b0;
          end
        end
        KEXP: begin
          rk_q  <= k_fwd;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd10) begin
            st_q    <= st_q ^ k_fwd;
            cnt_q   <= 4'd9;
            k10_c_q <= k_fwd;
            cv_q    <= KEY_CACHE;
            state_q <= DEC;
          end
        end
        DEC: begin
          rk_q  <= k_inv;
          st_q  <= rnd;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
// tb_aes_128_decrypt_iter: known-answer table, cache/backpressure/reset sequences and random blocks checked against an AES encryption model
module tb_aes_128_decrypt_iter;
  localparam logic [7:0]   AFF = 8'h63;
  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [127:0] ciphertext = '0, key = '0;
  logic ir1, ov1, ir0, ov0;
  logic [127:0] pt1, pt0;
  int tests = 0, fails = 0;
  logic [7:0] sb [256];
  typedef struct {
    logic [127:0] k, c, p;
    int l1, l0;
    bit gl;
    int stall;
  } vec_t;
  vec_t vt [5];
  always #5 clk = ~clk;
  aes_128_decrypt_iter #(.KEY_CACHE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .ciphertext(ciphertext), .key(key),
    .out_valid(ov1), .out_ready(out_ready), .plaintext(pt1)
  );
  aes_128_decrypt_iter #(.KEY_CACHE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .ciphertext(ciphertext), .key(key),
    .out_valid(ov0), .out_ready(out_ready), .plaintext(pt0)
  );
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction
  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc;
    logic [31:0] x;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) w[i] = k[127-32*i -: 32];
      else begin
        x = w[i-1];
        if (i % 4 == 0) begin
          x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]} ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end
        w[i] = w[i-4] ^ x;
      end
    end
    for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sb[s[4*(((j/4) + (j%4)) % 4) + (j%4)]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[4*c+q] = (r == 10 ? t[4*c+q] : gm(t[4*c+q], 8'h02) ^ gm(t[4*c+(q+1)%4], 8'h03) ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4])
                     ^ w[4*r+c][31-8*q -: 8];
    end
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input string nm, input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                     input int l1, input int l0, input bit gl, input int stall);
    int n, g1, g0;
    logic [127:0] q1, q0;
    bit ok;
    n = 0;
    while (!(ir1 && ir0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready"}, 128'(ir1 && ir0), 128'd1);
    out_ready = stall == 0;
    in_valid = 1'b1;
    ciphertext = c;
    key = k;
    @(negedge clk);
    in_valid = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    g1 = 0;
    g0 = 0;
    q1 = '0;
    q0 = '0;
    while ((g1 == 0 || g0 == 0) && n < 60) begin
      @(negedge clk);
      n++;
      in_valid = gl && n == 5;
      if (g1 == 0 && ov1) begin g1 = n; q1 = pt1; end
      if (g0 == 0 && ov0) begin g0 = n; q0 = pt0; end
    end
    in_valid = 1'b0;
    chk({nm, " latency cache"}, 128'(g1), 128'(l1));
    chk({nm, " plaintext cache"}, q1, p);
    chk({nm, " latency nocache"}, 128'(g0), 128'(l0));
    chk({nm, " plaintext nocache"}, q0, p);
    if (stall > 0) begin
      ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        ok = ok && ov1 && ov0 && pt1 == p && pt0 == p && !ir1 && !ir0;
      end
      chk({nm, " stall hold"}, 128'(ok), 128'd1);
      out_ready = 1'b1;
      @(negedge clk);
      chk({nm, " release ov1 ov0 ir1 ir0"}, 128'({ov1, ov0, ir1, ir0}), 128'(4'b0011));
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [127:0] rk, rp;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] v, s;
      v = '0;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) v = 8'(b);
      for (int j = 0; j < 8; j++) s[j] = v[j] ^ v[(j+4)%8] ^ v[(j+5)%8] ^ v[(j+6)%8] ^ v[(j+7)%8] ^ AFF[j];
      sb[a] = s;
    end
    vt[0] = '{K_C1, C_C1, P_C1, 20, 20, 1'b0, 0};
    vt[1] = '{K_B,  C_B,  P_B,  20, 20, 1'b0, 0};
    vt[2] = '{K_B,  C_B,  P_B,  10, 20, 1'b0, 0};
    vt[3] = '{K_C1, C_C1, P_C1, 20, 20, 1'b1, 0};
    vt[4] = '{K_B,  C_B,  P_B,  20, 20, 1'b0, 7};
    repeat (3) @(negedge clk);
    chk("reset in_ready", 128'({ir1, ir0}), 128'd0);
    chk("reset out_valid", 128'({ov1, ov0}), 128'd0);
    chk("reset plaintext", pt1 | pt0, 128'd0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", 128'({ir1, ir0}), 128'(2'b11));
    for (int i = 0; i < 5; i++)
      run($sformatf("vec%0d", i), vt[i].k, vt[i].c, vt[i].p, vt[i].l1, vt[i].l0, vt[i].gl, vt[i].stall);
    for (int i = 0; i < 6; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run($sformatf("rand%0d", i), rk, enc(rk, rp), rp, 20, 20, 1'b0, 0);
    end
    rp = {$urandom, $urandom, $urandom, $urandom};
    run("rand repeat-key", rk, enc(rk, rp), rp, 10, 20, 1'b0, 0);
    for (int i = 0; i < 100 && !(ir1 && ir0); i++) @(negedge clk);
    in_valid = 1'b1;
    ciphertext = C_C1;
    key = K_C1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun rst in_ready", 128'({ir1, ir0}), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun rst out_valid", 128'({ov1, ov0}), 128'd0);
    chk("midrun rst plaintext", pt1 | pt0, 128'd0);
    chk("midrun rst idle", 128'({ir1, ir0}), 128'(2'b11));
    run("after rst C1", K_C1, C_C1, P_C1, 20, 20, 1'b0, 0);
    run("after rst B", K_B, C_B, P_B, 20, 20, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
